// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// blank pattern, active-low GFEDCBA hex glyph table, lookup and index-width helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

  // Digit index width; never narrower than one bit.
  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = hex_to_glyph(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex display driver for a common-anode seven-segment display.
// Optional decimal-point support is built when SEG_SCAN_DP_EN is defined.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 100000,
  parameter int GUARD      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              segs,
  output logic                    frame_tick
`ifdef SEG_SCAN_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp
`endif
);

  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int SLOT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0] GUARD_CNT = SLOT_W'(GUARD);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_digits;
  logic [4*NUM_DIGITS-1:0] act_digits;
  logic [NUM_DIGITS-1:0]   pend_en;
  logic [NUM_DIGITS-1:0]   act_en;

  logic                    slot_wrap;
  logic                    boundary;
  logic                    in_guard;
  logic                    show;
  logic [3:0]              sel_nibble;
  logic [6:0]              sel_glyph;
  logic [NUM_DIGITS-1:0]   an_sel;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign boundary  = slot_wrap && (idx == IDX_LAST);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (slot_cnt < GUARD_CNT);
    end
  endgenerate

  assign sel_nibble = act_digits[{idx, 2'b00} +: 4];
  assign show       = !in_guard && act_en[idx];
  assign an_sel     = ~(NUM_DIGITS'(1) << idx);

  seven_seg_glyph u_glyph (
    .nibble (sel_nibble),
    .glyph  (sel_glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // load is a single-cycle strobe with no back-pressure: every asserted cycle
  // overwrites pending. Pending reaches the active set only at the frame
  // boundary, so a load in the boundary cycle waits one more frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_digits <= '0;
      pend_en     <= '0;
      act_digits  <= '0;
      act_en      <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_en     <= digit_en;
      end
      if (boundary) begin
        act_digits <= pend_digits;
        act_en     <= pend_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      segs       <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      an         <= show ? an_sel : '1;
      segs       <= show ? sel_glyph : SEG_BLANK;
      frame_tick <= (slot_cnt == '0) && (idx == '0);
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] act_dp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_dp <= '0;
      act_dp  <= '0;
      dp      <= 1'b1;
    end else begin
      if (load) begin
        pend_dp <= dp_in;
      end
      if (boundary) begin
        act_dp <= pend_dp;
      end
      dp <= show ? ~act_dp[idx] : 1'b1;
    end
  end
`endif

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed hex display driver for a NUM_DIGITS-digit common-anode seven-segment display.
- Accepts a packed bus of 4-bit digit values.
- Captures digit values on a load strobe and applies them only at frame boundaries, so a frame never tears.
- Scans the digits with a prescaled refresh counter, with a per-digit enable and an anti-ghosting guard interval.
- Sits between the arithmetic/register datapath and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
PRESCALE, 100000, clk cycles per digit slot (>= GUARD+2).
GUARD, 16, cycles at the start of each slot with all anodes off (0 disables the guard).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  single-cycle strobe; captures digits_in and digit_en into the pending registers
digits_in  in  4*NUM_DIGITS  digit k is bits [4k+3:4k]; digit 0 is the rightmost
digit_en  in  NUM_DIGITS  per-digit enable, 1 = shown
an  out  NUM_DIGITS  active-low one-hot anode select; all ones = dark
segs  out  7  active-low segments in GFEDCBA order
frame_tick  out  1  one-cycle pulse in the first cycle of the slot for digit 0

Behaviour:
- Reset (async, active-high): counters, digit index, pending and active registers, and frame_tick all 0.
  - an = all ones; segs = 7'b1111111.
  - Active and pending digit_en reset to all zeros, so the display stays dark until the first load plus frame boundary.
- Prescaler: slot_cnt counts 0..PRESCALE-1 and then wraps.
  - On wrap, idx increments.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle in which idx wraps to 0. In that cycle, pending digits and pending enables copy into the active registers.
- Load:
  - load=1 captures digits_in and digit_en into pending on that clk edge.
  - A later load before the boundary overwrites pending; last load wins.
  - If load coincides with the boundary cycle, the active registers take the old pending value and the new values wait for the next frame.
- Output registers: an and segs are registered, with 1-cycle latency from the (slot_cnt, idx) state.
  - During a slot with slot_cnt < GUARD: an = all ones, segs = all ones.
  - Otherwise, if active_en[idx]: an = ~(1<<idx) and segs = hex glyph of active digit idx.
  - Otherwise: an = all ones, segs = all ones.
- Glyphs (active low, GFEDCBA):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- frame_tick is registered and aligned with the first output cycle of the digit-0 slot.
- Invariant: at most one an bit is low in any cycle. Every idx change is preceded by at least GUARD dark cycles (when GUARD > 0).
- Reset asserted mid-slot: all outputs go dark immediately (asynchronous). Scanning restarts at idx 0, slot_cnt 0.

Optional Feature:
SEG_SCAN_DP_EN.
- Defined: adds input dp_in [NUM_DIGITS-1:0] and output dp (1 bit, active low).
  - dp_in is captured and transferred with load and the frame boundary, exactly like digits_in.
  - dp = ~active_dp[idx] while the digit is shown; 1 during guard, disabled slots and reset.
- Undefined: neither port exists and no dp registers are built.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_BLANK = 7'b1111111.
  - The 16-entry glyph constant table.
  - A function hex_to_glyph(nibble) returning 7 bits.
  - A localparam helper for the idx width, clog2(NUM_DIGITS), minimum 1.
- One sub-module, seven_seg_glyph: purely combinational nibble-to-glyph lookup using the package function. It is instantiated once on the selected digit.
- Prescaler, index, pending/active registers and output registers live in the top.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=4, GUARD=1.
1. Reset: hold rst, release, no load. Required: an=4'b1111 and segs=7'b1111111 for 3 full frames; frame_tick pulses every 16 cycles.
2. Basic scan: load digits_in=16'h3A70, digit_en=4'b1111; wait for the boundary. Required, per slot:
   - Digit 0: one dark cycle, then an=1110, segs=1000000 for 3 cycles.
   - Digit 1: an=1101, segs=1111000.
   - Digit 2: an=1011, segs=0001000.
   - Digit 3: an=0111, segs=0110000.
3. Tear-free update: mid-frame, load 16'hFFFF. Required: the remaining slots of the current frame still show 3A70; the next frame shows F on all digits.
4. Enable mask: load digit_en=4'b0101 with digits 16'h1234. Required: slots 1 and 3 show an=1111, segs blank; slots 0 and 2 show 4 (0011001) and 2 (0100100).
5. Load in the boundary cycle, plus async rst: load 16'h8888 in the exact boundary cycle; the following frame shows the old value and the one after shows 8 (0000000). Then assert rst mid-slot: outputs go dark in the same cycle, without waiting for a clock edge.
6. Invariant check (SVA or scoreboard, random loads, 10k cycles):
   - $countones(~an) <= 1 in every cycle.
   - An all-ones guard cycle precedes every anode change.
   - With SEG_SCAN_DP_EN defined, dp_in=4'b0010 gives dp=0 only in the digit-1 lit cycles.
